// File: rtl/spectrum_peak_decay.sv
// spectrum_peak_decay
//   Per-bin peak-hold/decay smoother for the FFT magnitude stream. Each bin outputs
//   max(new magnitude, decayed previous value), so bars rise fast and fall slowly.
//   Bin history is kept in an internal 2**ADDR_WIDTH x DATA_WIDTH RAM. After reset the
//   RAM is cleared one word per cycle before any samples are accepted.
//
//   state | meaning
//   CLEAR | zeroing history RAM, one address per cycle; busy=1; input ignored
//   RUN   | 3-stage read/modify/write pipeline, one sample per cycle
//
// Ports
//   FFT_clk   clock
//   rst       synchronous reset, active-low
//   in_we     magnitude sample valid
//   in_addr   bin index of the sample
//   in_data   unsigned magnitude
//   out_we    smoothed sample valid (single-cycle pulse per accepted sample)
//   out_addr  bin index of the smoothed sample
//   out_data  smoothed magnitude
//   busy      high while the history RAM is being cleared
module spectrum_peak_decay #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 9,
  parameter int DECAY_STEP   = 4,
  parameter int DECAY_FRAMES = 2
) (
  input  logic                  FFT_clk,
  input  logic                  rst,
  input  logic                  in_we,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int FRAME_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [FRAME_W-1:0]    LAST_FRAME = FRAME_W'(DECAY_FRAMES - 1);
  localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(DECAY_STEP);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clear_addr;
  logic [FRAME_W-1:0]      frame_cnt;
  logic                    accept;

  logic [DATA_WIDTH-1:0]   ram [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;

  logic                    s1_valid, s1_decay;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [DATA_WIDTH-1:0]   old_val, decayed, result;

  logic                    s2_valid;
  logic [ADDR_WIDTH-1:0]   s2_addr;
  logic [DATA_WIDTH-1:0]   s2_data;

  // FSM
  always_ff @(posedge FFT_clk) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clear_addr == '1) state_nxt = RUN;
      end
      RUN: ;
      default: state_nxt = CLEAR;
    endcase
  end

  assign accept = in_we && (state == RUN);

  always_ff @(posedge FFT_clk) begin
    if (!rst)                clear_addr <= '0;
    else if (state == CLEAR) clear_addr <= clear_addr + 1'b1;
  end

  // Frame counter advances on the last bin; that sample already captured the old decay_now.
  always_ff @(posedge FFT_clk) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (accept && (in_addr == '1)) begin
      frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 1'b1;
    end
  end

  // History RAM: one write port shared by clear and S2 writeback, one synchronous read.
  // The S2 write is held off on a reset edge so in-flight results are dropped.
  assign ram_we    = (state == CLEAR) || (s2_valid && rst);
  assign ram_waddr = (state == CLEAR) ? clear_addr : s2_addr;
  assign ram_wdata = (state == CLEAR) ? '0 : s2_data;

  always_ff @(posedge FFT_clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    rd_data <= ram[in_addr];
  end

  // S0 -> S1
  always_ff @(posedge FFT_clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_decay <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_decay <= (frame_cnt == LAST_FRAME);
        s1_addr  <= in_addr;
        s1_data  <= in_data;
      end
    end
  end

  // The RAM read in S0 misses the two younger results still in flight: the one in S2
  // (written next edge) and the one on the output registers (written on the same edge
  // as the read, so the read returned the older word). S2 is younger, so it wins.
  always_comb begin
    old_val = rd_data;
    if (s2_valid && (s2_addr == s1_addr))      old_val = s2_data;
    else if (out_we && (out_addr == s1_addr))  old_val = out_data;

    decayed = old_val;
    if (s1_decay) decayed = (old_val < STEP) ? '0 : old_val - STEP;

    result = (s1_data > decayed) ? s1_data : decayed;
  end

  // S1 -> S2
  always_ff @(posedge FFT_clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr <= s1_addr;
        s2_data <= result;
      end
    end
  end

  // S2 output registers, launched on the same edge as the RAM writeback
  always_ff @(posedge FFT_clk) begin
    if (!rst) begin
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_we <= s2_valid;
      if (s2_valid) begin
        out_addr <= s2_addr;
        out_data <= s2_data;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_peak_decay.sv
module tb_spectrum_peak_decay;

  logic       FFT_clk;
  logic       rst;
  logic       in_we;
  logic [7:0] in_addr;
  logic [8:0] in_data;
  logic       out_we;
  logic [7:0] out_addr;
  logic [8:0] out_data;
  logic       busy;

  spectrum_peak_decay #(
    .ADDR_WIDTH(8), .DATA_WIDTH(9), .DECAY_STEP(4), .DECAY_FRAMES(2)
  ) dut (
    .FFT_clk (FFT_clk),
    .rst     (rst),
    .in_we   (in_we),
    .in_addr (in_addr),
    .in_data (in_data),
    .out_we  (out_we),
    .out_addr(out_addr),
    .out_data(out_data),
    .busy    (busy)
  );

  initial FFT_clk = 1'b0;
  always #5 FFT_clk = ~FFT_clk;

  typedef struct packed {
    logic [7:0] a;
    logic [8:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge FFT_clk);
    #1;
  endtask

  task automatic push(input int a, input int d);
    exp_t e;
    e.a = 8'(a);
    e.d = 9'(d);
    exp_q.push_back(e);
  endtask

  // One sample per call; consecutive calls give back-to-back samples.
  task automatic send(input int a, input int d, input int exp_d);
    in_we   = 1'b1;
    in_addr = 8'(a);
    in_data = 9'(d);
    push(a, exp_d);
    tick();
    in_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge FFT_clk);
      if (out_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_we: got addr %0d data %0d, expected no output",
                   out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_addr", int'(out_addr), int'(e.a));
          chk("out_data", int'(out_data), int'(e.d));
        end
      end
    end
  endtask

  task automatic count_clear(input string tag);
    int n, bad;
    n = 0;
    bad = 0;
    while (busy && n < 1000) begin
      if (out_we) bad++;
      tick();
      n++;
    end
    chk({tag, "_busy_cycles"}, n, 256);
    chk({tag, "_out_we_in_clear"}, bad, 0);
  endtask

  initial begin
    rst     = 1'b0;
    in_we   = 1'b1;
    in_addr = 8'd10;
    in_data = 9'd0;
    fork
      monitor();
    join_none

    // Reset state, then CLEAR with in_we held high
    repeat (3) tick();
    chk("rst_out_we",   int'(out_we),   0);
    chk("rst_out_addr", int'(out_addr), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy",     int'(busy),     1);
    rst = 1'b1;
    count_clear("clear1");

    // First RUN accept: bin 10, data 0, non-decay frame
    push(10, 0);
    tick();
    in_we = 1'b0;
    tick();
    chk("latency_t1", int'(out_we), 0);
    tick();
    chk("latency_t2", int'(out_we), 1);
    drain();

    // frame_cnt=0 (non-decay)
    send(5, 100, 100);
    send(255, 0, 0);
    // frame_cnt=1 (decay)
    send(5, 0, 96);
    send(255, 0, 0);
    // frame_cnt=0
    send(5, 0, 96);
    send(9, 50, 50);
    send(3, 3, 3);
    send(255, 0, 0);
    // frame_cnt=1 (decay): bin5 decays, bin9 attack, bin3 saturates at 0
    send(5, 0, 92);
    send(9, 200, 200);
    send(3, 0, 0);
    send(255, 0, 0);
    drain();
    // frame_cnt=0: RAM holds attack value; back-to-back same bin; spacing-2 forwarding
    send(9, 0, 200);
    send(3, 0, 0);
    send(7, 10, 10);
    send(7, 30, 30);
    send(7, 20, 30);
    send(8, 1, 1);
    send(7, 5, 30);
    send(255, 0, 0);
    // frame_cnt=1 (decay)
    send(7, 0, 26);
    drain();

    // Reset with two samples in flight; neither may appear at the output
    in_we   = 1'b1;
    in_addr = 8'd20;
    in_data = 9'd50;
    tick();
    in_addr = 8'd21;
    tick();
    in_we = 1'b0;
    rst   = 1'b0;
    tick();
    chk("midrst_out_we", int'(out_we), 0);
    chk("midrst_busy",   int'(busy),   1);
    rst = 1'b1;
    count_clear("clear2");

    // History wiped and frame counter restarted at a non-decay frame
    send(5, 0, 0);
    send(20, 0, 0);
    send(9, 7, 7);
    drain();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
